ad_chan_merge: RTL and testbench

- Parametrised multi-channel ADC sample merger.
- Collects one sample per enabled channel for each sample epoch and stamps the frame with utc_sec/now_ns captured at the first channel's strobe.
- Buffers frames in a FIFO, then serialises them channel by channel onto a valid/ready data-path stream feeding the DSP/pack chain.
- Replaces the tied-off second and third ADC data paths; supports CH_NUM independent ADC fronts and exposes control/status on the fx bus.

---
 rtl/ad_chan_merge_if.sv | 33 +++
 rtl/ad_chan_merge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ad_chan_merge.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_chan_merge_if.sv
`default_nettype none
// ============================================================================
//  Module      : ad_chan_merge_if
//  Description : Valid/ready data-path stream carrying serialised ADC samples
//                with per-frame timestamp.
//                  dp_data - sample, dp_ch - channel index, dp_sof - first
//                  beat of frame, dp_utc/dp_ns - frame timestamp,
//                  dp_vld - beat valid, dp_rdy - downstream ready.
//                master: stream source (merger), slave: stream sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ad_chan_merge_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] dp_data;
    logic [2:0]        dp_ch;
    logic              dp_sof;
    logic [31:0]       dp_utc;
    logic [31:0]       dp_ns;
    logic              dp_vld;
    logic              dp_rdy;

    modport master (
        output dp_data, dp_ch, dp_sof, dp_utc, dp_ns, dp_vld,
        input  dp_rdy
    );

    modport slave (
        input  dp_data, dp_ch, dp_sof, dp_utc, dp_ns, dp_vld,
        output dp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/ad_chan_merge.sv
`default_nettype none
// ============================================================================
//  Module      : ad_chan_merge
//  Description : Multi-channel ADC sample merger. Collects one sample per
//                enabled channel per epoch, timestamps the frame at its first
//                strobe, buffers frames in a FIFO and serialises them channel
//                by channel onto the dp stream.
//  Ports       : clk_sys/rst          - clock, synchronous active-high reset
//                ad_data/ad_vld       - per-channel samples and strobes
//                utc_sec/now_ns       - free-running time of day
//                dp                   - output stream (master modport)
//                fx_*/mod_id          - control/status register bus
//  Revision    : 1.0 - initial release
// ============================================================================
module ad_chan_merge #(
    parameter int CH_NUM     = 3,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int TMO_CYC    = 1023
) (
    input  wire logic                     clk_sys,
    input  wire logic                     rst,
    input  wire logic [CH_NUM*DATA_W-1:0] ad_data,
    input  wire logic [CH_NUM-1:0]        ad_vld,
    input  wire logic [31:0]              utc_sec,
    input  wire logic [31:0]              now_ns,
    ad_chan_merge_if.master               dp,
    input  wire logic [15:0]              fx_waddr,
    input  wire logic                     fx_wr,
    input  wire logic [7:0]               fx_data,
    input  wire logic                     fx_rd,
    input  wire logic [15:0]              fx_raddr,
    output logic      [7:0]               fx_q,
    input  wire logic [5:0]               mod_id
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_sw = CH_NUM * DATA_W;
    // Frame word: {utc, ns, mask, samples}
    localparam int c_fw = 64 + CH_NUM + c_sw;
    localparam int c_cw = $clog2(TMO_CYC + 1);
    localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TMO_CYC - 1);

    typedef enum logic [1:0] {C_IDLE, C_COLLECT, C_PUSH} col_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} ser_t;

    // ---------------- control / status ----------------
    logic [CH_NUM-1:0] r_ch_en;
    logic              r_enable, r_ovf, r_tmo;
    logic [7:0]        r_drop;
    logic [7:0]        w_rdata;
    logic              w_wsel, w_rsel, w_clr;

    // ---------------- collector ----------------
    col_t              r_cst;
    logic [CH_NUM-1:0] r_mask, r_got;
    logic [c_sw-1:0]   r_samp;
    logic [31:0]       r_utc, r_ns;
    logic [c_cw-1:0]   r_cnt;
    logic [CH_NUM-1:0] w_hit, w_new;
    logic [c_sw-1:0]   w_start_samp, w_col_samp;
    logic              w_can_start, w_got_all, w_tmo_evt;

    // ---------------- FIFO ----------------
    logic [c_fw-1:0]   r_mem [FIFO_DEPTH];
    logic [c_aw:0]     r_wp, r_rp;
    logic [c_aw:0]     w_rp_nxt;
    logic              w_empty, w_full, w_has_next, w_push_req, w_push, w_pop;
    logic [c_fw-1:0]   w_head, w_next;

    // ---------------- serialiser ----------------
    ser_t              r_sst;
    logic [CH_NUM-1:0] r_rem;
    logic              w_sel_next;
    logic [c_fw-1:0]   w_src;
    logic [CH_NUM-1:0] w_rem_src, w_rem_after;
    logic [2:0]        w_idx;
    logic [DATA_W-1:0] w_bdata;

    assign w_wsel = fx_wr && (fx_waddr[15:10] == mod_id);
    assign w_rsel = fx_rd && (fx_raddr[15:10] == mod_id);
    assign w_clr  = w_wsel && (fx_waddr[9:0] == 10'h001) && fx_data[1];

    always_comb begin
        w_rdata = 8'h00;
        case (fx_raddr[9:0])
            10'h000: w_rdata[CH_NUM-1:0] = r_ch_en;
            10'h001: w_rdata[0]          = r_enable;
            10'h002: w_rdata[3:0]        = {w_full, w_empty, r_tmo, r_ovf};
            10'h003: w_rdata             = r_drop;
            default: w_rdata             = 8'h00;
        endcase
    end

    // Collector next-state helpers
    assign w_hit       = ad_vld & r_ch_en;
    assign w_can_start = r_enable && (|w_hit);
    assign w_new       = ad_vld & r_mask & ~r_got;
    assign w_got_all   = ((r_got | w_new) == r_mask);
    assign w_tmo_evt   = (r_cst == C_COLLECT) && !w_got_all && (r_cnt == c_tmo_last);

    // Non-striking channels start at 0 so a timed-out frame carries zeros.
    always_comb begin
        w_start_samp = '0;
        w_col_samp   = r_samp;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_hit[k]) w_start_samp[k*DATA_W +: DATA_W] = ad_data[k*DATA_W +: DATA_W];
            if (w_new[k]) w_col_samp[k*DATA_W +: DATA_W]   = ad_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_cst  <= C_IDLE;
            r_mask <= '0;
            r_got  <= '0;
            r_samp <= '0;
            r_utc  <= '0;
            r_ns   <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_cst)
                C_IDLE, C_PUSH: begin
                    r_got <= '0;
                    r_cst <= C_IDLE;
                    if (w_can_start) begin
                        r_mask <= r_ch_en;
                        r_got  <= w_hit;
                        r_samp <= w_start_samp;
                        r_utc  <= utc_sec;
                        r_ns   <= now_ns;
                        r_cnt  <= '0;
                        r_cst  <= (w_hit == r_ch_en) ? C_PUSH : C_COLLECT;
                    end
                end
                C_COLLECT: begin
                    r_samp <= w_col_samp;
                    r_got  <= r_got | w_new;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_got_all || (r_cnt == c_tmo_last)) r_cst <= C_PUSH;
                end
                default: r_cst <= C_IDLE;
            endcase
        end
    end

    // FIFO: extra pointer bit distinguishes full from empty.
    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[c_aw] != r_rp[c_aw]) && (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
    assign w_rp_nxt   = r_rp + 1'b1;
    assign w_has_next = (w_rp_nxt != r_wp);
    assign w_head     = r_mem[r_rp[c_aw-1:0]];
    assign w_next     = r_mem[w_rp_nxt[c_aw-1:0]];
    assign w_push_req = (r_cst == C_PUSH);
    assign w_push     = w_push_req && (!w_full || w_pop);
    // The frame stays in the FIFO until its last beat is accepted.
    assign w_pop      = (r_sst == S_SEND) && dp.dp_rdy && (r_rem == '0);

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wp[c_aw-1:0]] <= {r_utc, r_ns, r_mask, r_samp};
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= w_rp_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_ch_en  <= '1;
            r_enable <= 1'b1;
            r_ovf    <= 1'b0;
            r_tmo    <= 1'b0;
            r_drop   <= 8'h00;
            fx_q     <= 8'h00;
        end else begin
            fx_q <= w_rsel ? w_rdata : 8'h00;
            if (w_wsel && (fx_waddr[9:0] == 10'h000)) r_ch_en  <= fx_data[CH_NUM-1:0];
            if (w_wsel && (fx_waddr[9:0] == 10'h001)) r_enable <= fx_data[0];
            if (w_clr) begin
                r_ovf  <= 1'b0;
                r_tmo  <= 1'b0;
                r_drop <= 8'h00;
            end else begin
                if (w_tmo_evt) r_tmo <= 1'b1;
                if (w_push_req && !w_push) begin
                    r_ovf <= 1'b1;
                    if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
                end
            end
        end
    end

    // Once the current frame is exhausted the next head frame is read
    // directly so back-to-back frames stream without a bubble.
    assign w_sel_next = (r_sst == S_SEND) && (r_rem == '0);
    assign w_src      = w_sel_next ? w_next : w_head;
    assign w_rem_src  = w_sel_next ? w_src[c_sw +: CH_NUM] : r_rem;

    // Lowest remaining channel wins.
    always_comb begin
        w_idx       = 3'd0;
        w_bdata     = w_src[DATA_W-1:0];
        w_rem_after = w_rem_src;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (w_rem_src[k]) begin
                w_idx          = 3'(k);
                w_bdata        = w_src[k*DATA_W +: DATA_W];
                w_rem_after    = w_rem_src;
                w_rem_after[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_sst      <= S_IDLE;
            r_rem      <= '0;
            dp.dp_data <= '0;
            dp.dp_ch   <= '0;
            dp.dp_sof  <= 1'b0;
            dp.dp_utc  <= '0;
            dp.dp_ns   <= '0;
            dp.dp_vld  <= 1'b0;
        end else begin
            case (r_sst)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_rem <= w_head[c_sw +: CH_NUM];
                        r_sst <= S_LOAD;
                    end
                end
                S_LOAD, S_SEND: begin
                    if ((r_sst == S_LOAD) || dp.dp_rdy) begin
                        if ((r_sst == S_LOAD) || (r_rem != '0) || w_has_next) begin
                            dp.dp_data <= w_bdata;
                            dp.dp_ch   <= w_idx;
                            dp.dp_sof  <= (r_sst == S_LOAD) || w_sel_next;
                            dp.dp_utc  <= w_src[c_fw-1 -: 32];
                            dp.dp_ns   <= w_src[c_fw-33 -: 32];
                            dp.dp_vld  <= 1'b1;
                            r_rem      <= w_rem_after;
                            r_sst      <= S_SEND;
                        end else begin
                            dp.dp_vld <= 1'b0;
                            dp.dp_sof <= 1'b0;
                            r_sst     <= S_IDLE;
                        end
                    end
                end
                default: r_sst <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ad_chan_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ad_chan_merge
//  Description : Directed self-checking bench for ad_chan_merge
//                (CH_NUM=3, DATA_W=24, FIFO_DEPTH=8, TMO_CYC=1023).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_chan_merge;
    localparam logic [5:0] c_id = 6'h05;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [71:0] ad_data;
    logic [2:0]  ad_vld;
    logic [31:0] utc_sec, now_ns;
    logic [15:0] fx_waddr, fx_raddr;
    logic        fx_wr, fx_rd;
    logic [7:0]  fx_data, fx_q;
    logic [5:0]  mod_id;
    logic [7:0]  rd;

    int n_err = 0;
    int n_chk = 0;

    logic [91:0] got_q[$];
    logic [91:0] exp_q[$];
    logic        stall_v = 1'b0;
    logic [91:0] stall_beat;

    ad_chan_merge_if #(.DATA_W(24)) dp_if ();

    ad_chan_merge #(
        .CH_NUM(3), .DATA_W(24), .FIFO_DEPTH(8), .TMO_CYC(1023)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .ad_data(ad_data), .ad_vld(ad_vld),
        .utc_sec(utc_sec), .now_ns(now_ns), .dp(dp_if.master),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data), .fx_rd(fx_rd),
        .fx_raddr(fx_raddr), .fx_q(fx_q), .mod_id(mod_id)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [91:0] cur_beat();
        return {dp_if.dp_data, dp_if.dp_ch, dp_if.dp_sof, dp_if.dp_utc, dp_if.dp_ns};
    endfunction

    function automatic logic [91:0] bt(input logic [23:0] d, input logic [2:0] ch,
                                       input logic sof, input logic [31:0] u, input logic [31:0] n);
        return {d, ch, sof, u, n};
    endfunction

    function automatic logic [23:0] fd(input int f, input int k);
        return 24'hA00000 + 24'(f * 16 + k);
    endfunction

    // Beat monitor: sampled mid-cycle, ahead of the accepting edge.
    always @(negedge clk_sys) begin
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) chk("stall_hold", {dp_if.dp_vld, cur_beat()}, {1'b1, stall_beat});
            if (dp_if.dp_vld && dp_if.dp_rdy) got_q.push_back(cur_beat());
            stall_v    = dp_if.dp_vld && !dp_if.dp_rdy;
            stall_beat = cur_beat();
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [2:0] v, input logic [71:0] d);
        ad_vld  = v;
        ad_data = d;
        tick();
        ad_vld  = 3'b000;
    endtask

    task automatic fx_write(input logic [9:0] a, input logic [7:0] d);
        fx_waddr = {c_id, a};
        fx_data  = d;
        fx_wr    = 1'b1;
        tick();
        fx_wr    = 1'b0;
    endtask

    task automatic fx_read(input logic [15:0] a, output logic [7:0] q);
        fx_raddr = a;
        fx_rd    = 1'b1;
        tick();
        fx_rd    = 1'b0;
        q        = fx_q;
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_vld(input string tag, input int limit);
        for (int i = 0; i < limit && !dp_if.dp_vld; i++) tick();
        chk(tag, 128'(dp_if.dp_vld), 128'(1));
    endtask

    initial begin
        rst = 1'b1; ad_data = '0; ad_vld = '0; utc_sec = '0; now_ns = '0;
        fx_waddr = '0; fx_raddr = '0; fx_wr = 1'b0; fx_rd = 1'b0; fx_data = '0;
        mod_id = c_id; dp_if.dp_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_vld", 128'(dp_if.dp_vld), 128'(0));
        chk("rst_data", 128'(dp_if.dp_data), 128'(0));
        chk("rst_fxq", 128'(fx_q), 128'(0));
        rst = 1'b0;
        tick();
        fx_read({c_id, 10'h000}, rd); chk("rst_ch_en", 128'(rd), 128'h07);
        fx_read({c_id, 10'h001}, rd); chk("rst_ctrl", 128'(rd), 128'h01);
        fx_read({c_id, 10'h002}, rd); chk("rst_status", 128'(rd), 128'h04);
        fx_read({6'h06, 10'h000}, rd); chk("unsel_read", 128'(rd), 128'h00);

        // Basic 3-channel frame and latency
        utc_sec = 5; now_ns = 100;
        strobe(3'b001, {24'h0, 24'h0, 24'h111111});
        utc_sec = 6; now_ns = 200;
        strobe(3'b010, {24'h0, 24'h222222, 24'h0});
        strobe(3'b100, {24'h333333, 24'h0, 24'h0});
        tick(); tick();
        chk("lat_n2_vld", 128'(dp_if.dp_vld), 128'(0));
        tick();
        chk("lat_n3_vld", 128'(dp_if.dp_vld), 128'(1));
        exp_q.push_back(bt(24'h111111, 3'd0, 1'b1, 5, 100));
        exp_q.push_back(bt(24'h222222, 3'd1, 1'b0, 5, 100));
        exp_q.push_back(bt(24'h333333, 3'd2, 1'b0, 5, 100));
        repeat (8) tick();
        check_beats("basic");
        tick();
        chk("fxq_idle", 128'(fx_q), 128'(0));

        // Sparse mask, then disable mask mid-frame
        fx_write(10'h000, 8'h05);
        utc_sec = 10; now_ns = 1;
        strobe(3'b111, {24'hC3C3C3, 24'hB3B3B3, 24'hA3A3A3});
        exp_q.push_back(bt(24'hA3A3A3, 3'd0, 1'b1, 10, 1));
        exp_q.push_back(bt(24'hC3C3C3, 3'd2, 1'b0, 10, 1));
        repeat (8) tick();
        utc_sec = 11; now_ns = 2;
        strobe(3'b001, {24'h0, 24'h0, 24'hA4A4A4});
        fx_write(10'h000, 8'h00);
        strobe(3'b100, {24'hC4C4C4, 24'h0, 24'h0});
        exp_q.push_back(bt(24'hA4A4A4, 3'd0, 1'b1, 11, 2));
        exp_q.push_back(bt(24'hC4C4C4, 3'd2, 1'b0, 11, 2));
        repeat (10) tick();
        check_beats("mask5");
        strobe(3'b111, {24'h1, 24'h2, 24'h3});
        repeat (10) tick();
        check_beats("ch_en0");
        fx_read({c_id, 10'h000}, rd); chk("ch_en0_read", 128'(rd), 128'h00);
        fx_write(10'h000, 8'h07);

        // Timeout: ch2 never strobes
        dp_if.dp_rdy = 1'b0;
        utc_sec = 20; now_ns = 30;
        strobe(3'b001, {24'h0, 24'h0, 24'hA5A5A5});
        strobe(3'b010, {24'h0, 24'hB5B5B5, 24'h0});
        wait_vld("tmo_wait", 1200);
        fx_read({c_id, 10'h002}, rd); chk("tmo_status", 128'(rd), 128'h02);
        dp_if.dp_rdy = 1'b1;
        exp_q.push_back(bt(24'hA5A5A5, 3'd0, 1'b1, 20, 30));
        exp_q.push_back(bt(24'hB5B5B5, 3'd1, 1'b0, 20, 30));
        exp_q.push_back(bt(24'h000000, 3'd2, 1'b0, 20, 30));
        repeat (8) tick();
        check_beats("tmo");
        fx_read({c_id, 10'h002}, rd); chk("tmo_status_drained", 128'(rd), 128'h06);
        fx_write(10'h001, 8'h03);
        fx_read({c_id, 10'h002}, rd); chk("tmo_clr_status", 128'(rd), 128'h04);
        fx_read({c_id, 10'h001}, rd); chk("ctrl_after_clr", 128'(rd), 128'h01);

        // Overflow: 10 frames into an 8-deep FIFO while stalled
        dp_if.dp_rdy = 1'b0;
        for (int f = 0; f < 10; f++) begin
            utc_sec = 32'(100 + f); now_ns = 32'(f);
            strobe(3'b111, {fd(f, 2), fd(f, 1), fd(f, 0)});
            if (f < 8)
                for (int k = 0; k < 3; k++)
                    exp_q.push_back(bt(fd(f, k), 3'(k), k == 0, 32'(100 + f), 32'(f)));
            tick(); tick();
        end
        repeat (3) tick();
        fx_read({c_id, 10'h002}, rd); chk("ovf_status", 128'(rd), 128'h09);
        fx_read({c_id, 10'h003}, rd); chk("ovf_drop_cnt", 128'(rd), 128'h02);
        dp_if.dp_rdy = 1'b1;
        repeat (40) tick();
        check_beats("ovf");
        fx_write(10'h001, 8'h03);
        fx_read({c_id, 10'h002}, rd); chk("ovf_clr_status", 128'(rd), 128'h04);
        fx_read({c_id, 10'h003}, rd); chk("ovf_clr_drop", 128'(rd), 128'h00);

        // Random back-pressure
        for (int f = 0; f < 5; f++) begin
            utc_sec = 32'(300 + f); now_ns = 32'(7 * f);
            dp_if.dp_rdy = 1'($urandom_range(0, 1));
            strobe(3'b111, {fd(f + 16, 2), fd(f + 16, 1), fd(f + 16, 0)});
            for (int k = 0; k < 3; k++)
                exp_q.push_back(bt(fd(f + 16, k), 3'(k), k == 0, 32'(300 + f), 32'(7 * f)));
            for (int c = 0; c < 3; c++) begin
                dp_if.dp_rdy = 1'($urandom_range(0, 1));
                tick();
            end
        end
        for (int c = 0; c < 40; c++) begin
            dp_if.dp_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        dp_if.dp_rdy = 1'b1;
        repeat (25) tick();
        check_beats("rand");

        // Reset mid-frame while dp_vld is high
        dp_if.dp_rdy = 1'b0;
        utc_sec = 50; now_ns = 60;
        strobe(3'b111, {24'h0C0C0C, 24'h0B0B0B, 24'h0A0A0A});
        wait_vld("prerst_wait", 20);
        fx_write(10'h000, 8'h03);
        strobe(3'b001, {24'h0, 24'h0, 24'h0D0D0D});
        rst = 1'b1;
        tick();
        chk("rst_mid_vld", 128'(dp_if.dp_vld), 128'(0));
        rst = 1'b0;
        fx_read({c_id, 10'h002}, rd); chk("rst_mid_status", 128'(rd), 128'h04);
        fx_read({c_id, 10'h000}, rd); chk("rst_mid_ch_en", 128'(rd), 128'h07);
        dp_if.dp_rdy = 1'b1;
        utc_sec = 77; now_ns = 88;
        strobe(3'b001, {24'h0, 24'h0, 24'h717171});
        strobe(3'b010, {24'h0, 24'h727272, 24'h0});
        strobe(3'b100, {24'h737373, 24'h0, 24'h0});
        exp_q.push_back(bt(24'h717171, 3'd0, 1'b1, 77, 88));
        exp_q.push_back(bt(24'h727272, 3'd1, 1'b0, 77, 88));
        exp_q.push_back(bt(24'h737373, 3'd2, 1'b0, 77, 88));
        repeat (10) tick();
        check_beats("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
